// File: rtl/multi_cycle_add_sub.sv
// multi_cycle_add_sub
//   Slice-serial adder/subtractor. Each cycle in RUN it processes SLICE bits
//   of the latched operands and keeps the carry/borrow between slices in a
//   chain register. The full result is presented after NSLICE = WIDTH/SLICE
//   cycles, together with a one-cycle done pulse.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled only while busy = 0
//   SUB    : 1 = A - B - Bin, 0 = A + B + Bin (latched at accept)
//   A, B   : operands (latched at accept)
//   Bin    : borrow-in / carry-in (latched at accept)
//   D      : result register
//   Bout   : borrow-out / carry-out
//   OVF    : two's-complement signed overflow
//   ZERO   : D == 0, registered together with D
//   busy   : operation in progress
//   done   : one-cycle pulse when D and the flags update
module multi_cycle_add_sub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             OVF,
  output logic             ZERO,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             chain_q, chain_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [31:0]      shamt;
  logic [SLICE-1:0] a_sl, b_sl, r_sl;
  logic             c_out;
  logic [WIDTH-1:0] acc_next;
  logic             last;

  // Slice datapath: select slice cnt_q of each operand and ripple through it.
  always_comb begin
    shamt = 32'(cnt_q) * 32'(SLICE);
    a_sl  = SLICE'(a_q >> shamt);
    b_sl  = SLICE'(b_q >> shamt);
    r_sl  = '0;
    c_out = chain_q;
    for (int unsigned i = 0; i < SLICE; i++) begin
      r_sl[i] = a_sl[i] ^ b_sl[i] ^ c_out;
      if (sub_q)
        c_out = (~a_sl[i] & b_sl[i]) | (~(a_sl[i] ^ b_sl[i]) & c_out);
      else
        c_out = (a_sl[i] & b_sl[i]) | (c_out & (a_sl[i] ^ b_sl[i]));
    end
    // Accumulator is cleared at accept, so OR-ing the slice in is sufficient.
    acc_next = acc_q | (WIDTH'(r_sl) << shamt);
    last     = (cnt_q == CW'(NSLICE - 1));
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    chain_d = chain_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sub_d   = SUB;
          a_d     = A;
          b_d     = B;
          chain_d = Bin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_next;
        chain_d = c_out;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          d_d     = acc_next;
          bout_d  = c_out;
          zero_d  = (acc_next == '0);
          if (sub_q)
            ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
          else
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      chain_q <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign OVF  = ovf_q;
  assign ZERO = zero_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: tb/tb_multi_cycle_add_sub.sv
// Bench for multi_cycle_add_sub: three instances (SLICE = 8, 32, 1) at
// WIDTH = 32. Stimulus pushes hand-computed results into a scoreboard queue;
// a negedge monitor pops and compares whenever an instance pulses done.
module tb_multi_cycle_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start;
  logic        sub_i, bin_i;
  logic [31:0] a_i, b_i;

  logic [31:0] d_w    [3];
  logic        bout_w [3];
  logic        ovf_w  [3];
  logic        zero_w [3];
  logic        busy_w [3];
  logic        done_w [3];

  always #5 clk = ~clk;

  multi_cycle_add_sub #(.WIDTH(32), .SLICE(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .SUB(sub_i), .A(a_i), .B(b_i),
    .Bin(bin_i), .D(d_w[0]), .Bout(bout_w[0]), .OVF(ovf_w[0]), .ZERO(zero_w[0]),
    .busy(busy_w[0]), .done(done_w[0]));

  multi_cycle_add_sub #(.WIDTH(32), .SLICE(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .SUB(sub_i), .A(a_i), .B(b_i),
    .Bin(bin_i), .D(d_w[1]), .Bout(bout_w[1]), .OVF(ovf_w[1]), .ZERO(zero_w[1]),
    .busy(busy_w[1]), .done(done_w[1]));

  multi_cycle_add_sub #(.WIDTH(32), .SLICE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .SUB(sub_i), .A(a_i), .B(b_i),
    .Bin(bin_i), .D(d_w[2]), .Bout(bout_w[2]), .OVF(ovf_w[2]), .ZERO(zero_w[2]),
    .busy(busy_w[2]), .done(done_w[2]));

  typedef struct {
    int unsigned id;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
    longint      exp_cyc;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;
  logic [31:0] d_hold  [3];
  longint      done_at [3];
  longint      prev_at [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int unsigned id);
    case (id)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: done/busy exclusion, D stable while busy, scoreboard on done.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i]) chk($sformatf("d_hold_run[%0d]", i), d_w[i], d_hold[i]);
        if (done_w[i]) begin
          int idx;
          chk($sformatf("busy_in_done[%0d]", i), 32'(busy_w[i]), 32'd0);
          idx = -1;
          for (int j = 0; j < sbq.size(); j++)
            if (idx < 0 && sbq[j].id == i) idx = j;
          if (idx < 0) begin
            chk($sformatf("unexpected_done[%0d]", i), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sbq[idx];
            sbq.delete(idx);
            chk($sformatf("D[%0d]", i),       d_w[i],           e.d);
            chk($sformatf("Bout[%0d]", i),    32'(bout_w[i]),   32'(e.bout));
            chk($sformatf("OVF[%0d]", i),     32'(ovf_w[i]),    32'(e.ovf));
            chk($sformatf("ZERO[%0d]", i),    32'(zero_w[i]),   32'(e.zero));
            chk($sformatf("latency[%0d]", i), 32'(cyc),         32'(e.exp_cyc));
            d_hold[i]  = e.d;
          end
          prev_at[i] = done_at[i];
          done_at[i] = cyc;
        end
      end
    end
  end

  // Drive a request now; the next rising edge is the accept edge.
  task automatic issue(input int unsigned id, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic bi, input logic [31:0] ed,
                       input logic eb, input logic eo, input logic ez);
    exp_t e;
    sub_i = s; a_i = a; b_i = b; bin_i = bi;
    start[id] = 1'b1;
    @(posedge clk);
    #1;
    start[id] = 1'b0;
    e.id = id; e.d = ed; e.bout = eb; e.ovf = eo; e.zero = ez;
    e.exp_cyc = cyc + lat(id);
    sbq.push_back(e);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(negedge clk);
    chk("drain", sbq.size(), 32'd0);
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    while (!done_w[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done0", 32'(done_w[0]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = '0; sub_i = 1'b0; bin_i = 1'b0; a_i = '0; b_i = '0;
    for (int i = 0; i < 3; i++) begin d_hold[i] = '0; done_at[i] = 0; prev_at[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_D",    d_w[0],            32'd0);
    chk("rst_ZERO", 32'(zero_w[0]),    32'd1);
    chk("rst_busy", 32'(busy_w[0]),    32'd0);
    chk("rst_done", 32'(done_w[0]),    32'd0);
    chk("rst_Bout", 32'(bout_w[0]),    32'd0);
    chk("rst_OVF",  32'(ovf_w[0]),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // id, SUB, A, B, Bin -> D, Bout, OVF, ZERO
    issue(0, 1, 32'h00000005, 32'h00000003, 0, 32'h00000002, 0, 0, 0); drain();
    issue(0, 1, 32'h00000000, 32'h00000001, 0, 32'hFFFFFFFF, 1, 0, 0); drain();
    issue(0, 1, 32'h00000100, 32'h00000001, 0, 32'h000000FF, 0, 0, 0); drain();
    issue(0, 1, 32'h80000000, 32'h00000001, 0, 32'h7FFFFFFF, 0, 1, 0); drain();
    issue(0, 0, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1, 0); drain();
    issue(0, 0, 32'hFFFFFFFF, 32'h00000000, 1, 32'h00000000, 1, 0, 1); drain();
    issue(0, 1, 32'h00000005, 32'h00000005, 1, 32'hFFFFFFFF, 1, 0, 0); drain();
    issue(0, 1, 32'h00000005, 32'h00000005, 0, 32'h00000000, 0, 0, 1); drain();
    issue(0, 0, 32'h12345678, 32'h0FEDCBA9, 0, 32'h22222221, 0, 0, 0); drain();
    issue(0, 0, 32'h000000FF, 32'h00000001, 0, 32'h00000100, 0, 0, 0); drain();
    issue(0, 1, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 32'h80000000, 1, 1, 0); drain();

    // start held with new operands during RUN must be ignored
    issue(0, 1, 32'h00000005, 32'h00000003, 0, 32'h00000002, 0, 0, 0);
    sub_i = 1'b0; a_i = 32'hFFFFFFFF; b_i = 32'h00000001; bin_i = 1'b1;
    start[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start[0] = 1'b0;
    drain();

    // back-to-back: second start issued in the done cycle
    issue(0, 0, 32'h00000001, 32'h00000002, 0, 32'h00000003, 0, 0, 0);
    wait_done0();
    issue(0, 1, 32'h0000000A, 32'h00000004, 0, 32'h00000006, 0, 0, 0);
    drain();
    chk("b2b_gap", 32'(done_at[0] - prev_at[0]), 32'd5);

    // reset during the second RUN cycle aborts the operation
    issue(0, 1, 32'h00000100, 32'h00000001, 0, 32'h000000FF, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_D",    d_w[0],         32'd0);
    chk("abort_ZERO", 32'(zero_w[0]), 32'd1);
    chk("abort_done", 32'(done_w[0]), 32'd0);
    sbq.delete();
    for (int i = 0; i < 3; i++) d_hold[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // latency variants
    issue(1, 1, 32'h00000005, 32'h00000003, 0, 32'h00000002, 0, 0, 0); drain();
    issue(1, 0, 32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 0, 1, 0); drain();
    issue(2, 1, 32'h00000005, 32'h00000003, 0, 32'h00000002, 0, 0, 0); drain();
    issue(2, 1, 32'h00000000, 32'h00000001, 0, 32'hFFFFFFFF, 1, 0, 0); drain();

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_cycle_add_sub.md
# multi_cycle_add_sub

Parametrised, slice-serial adder/subtractor that generalises the team's 32-bit ripple full subtractor. It adds width and slice-size parameters, an add/subtract mode, a start/done handshake, and signed-overflow and zero flags. Each cycle it processes SLICE bits of the operands and carries the borrow or carry between slices in a register. It sits in the datapath next to the combinational ALU, for wide operands where a full-width ripple chain would miss timing.

## Interface
- WIDTH, 32: operand/result width in bits; must be ≥ 2.
- SLICE, 8: bits processed per cycle; must divide WIDTH exactly; SLICE = WIDTH gives single-cycle processing.
- NSLICE (localparam) = WIDTH/SLICE: latency in cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy = 0.
- SUB  in  1  mode, latched at accept: 1 = A − B − Bin, 0 = A + B + Bin.
- A  in  WIDTH  first operand, latched at accept.
- B  in  WIDTH  second operand, latched at accept.
- Bin  in  1  borrow-in (SUB = 1) or carry-in (SUB = 0), latched at accept.
- D  out  WIDTH  result register.
- Bout  out  1  borrow-out (SUB = 1) or carry-out (SUB = 0).
- OVF  out  1  two's-complement signed overflow.
- ZERO  out  1  D == 0.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: D and flags updated.

## Operation
- FSM has two states:
  - IDLE: busy = 0. start = 1 at a rising edge latches SUB, A, B and Bin, clears the slice counter, and loads the chain register with Bin. Next state RUN.
  - RUN: busy = 1. At each edge, slice i (bits i*SLICE+SLICE−1 : i*SLICE) is computed from the latched operands and the chain register. The slice result goes into an internal accumulator, the slice borrow/carry goes into the chain register, and i increments.
  - After slice NSLICE−1: D ← accumulator, Bout ← final chain bit, OVF and ZERO computed, done = 1. Next state IDLE.
- Subtract, per bit: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
- Add, per bit: s = a ^ b ^ cin; cout = (a & b) | (cin & (a ^ b)).
- Arithmetic rules:
  - Results are modulo 2^WIDTH.
  - Bout = 1 exactly when the unsigned A < B + Bin (subtract) or when A + B + Bin ≥ 2^WIDTH (add).
- Flags:
  - OVF for subtract: A[MSB] ≠ B[MSB] and D[MSB] ≠ A[MSB].
  - OVF for add: A[MSB] == B[MSB] and D[MSB] ≠ A[MSB].
  - ZERO is registered with D, not decoded combinationally from live inputs.
- D, Bout, OVF and ZERO hold their previous values throughout RUN and change only on the completion edge.
- start while busy = 1 is ignored. Changes to A, B, SUB or Bin during RUN have no effect.

## Timing
- Reset, asynchronous on rst_n = 0:
  - State → IDLE.
  - D = 0, Bout = 0, OVF = 0, ZERO = 1, busy = 0, done = 0.
  - Internal accumulator, counter and chain register are cleared.
- Reset asserted mid-operation aborts the operation; no done pulse follows.
- Accept edge k: start = 1 and IDLE at edge k; busy = 1 from after edge k.
- Completion:
  - Edges k+1 through k+NSLICE process slices 0 through NSLICE−1.
  - After edge k+NSLICE: done = 1 for exactly one cycle, busy = 0, and D and the flags are valid.
- Back-to-back: start = 1 in the done cycle is accepted at the next edge. Sustained throughput is one result per NSLICE+1 cycles.
- done and busy are never 1 in the same cycle.

## Test plan
- WIDTH = 32, SLICE = 8, SUB = 1: A = 0x00000005, B = 0x00000003, Bin = 0, start pulse → done exactly 4 cycles after accept. D = 0x00000002, Bout = 0, OVF = 0, ZERO = 0.
- Borrow crosses slice boundaries, SUB = 1: A = 0x00000000, B = 0x00000001, Bin = 0 → D = 0xFFFFFFFF, Bout = 1, OVF = 0. Also A = 0x00000100, B = 0x00000001 → D = 0x000000FF, Bout = 0.
- Signed overflow, SUB = 1: A = 0x80000000, B = 0x00000001, Bin = 0 → D = 0x7FFFFFFF, OVF = 1, Bout = 0. With SUB = 0: A = 0x7FFFFFFF, B = 0x00000001 → D = 0x80000000, OVF = 1.
- Add with carry-in, SUB = 0: A = 0xFFFFFFFF, B = 0x00000000, Bin = 1 → D = 0x00000000, Bout = 1, ZERO = 1.
- Handshake:
  - start held high with new operands during RUN → ignored; the result matches the first accepted operands.
  - start in the done cycle → accepted; the second done arrives 5 cycles after the first.
- Reset: drop rst_n at cycle 2 of RUN → immediately busy = 0, D = 0, ZERO = 1, no done pulse. Repeat the first scenario with SLICE = 32 (latency 1) and SLICE = 1 (latency 32).
